fwrisc_prog_loader: RTL

//  Program-load stage between UART_rx_fsm (byte source) and the instruction ROM/ITCM write port.

---
 rtl/fwrisc_loader_pkg.sv | 19 +
 rtl/fwrisc_byte_packer.sv | 47 ++++
 rtl/fwrisc_prog_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fwrisc_loader_pkg.sv
// Shared state encoding and default parameters for the FWRISC program loader.
// The end marker default can be overridden per instance through the END_MARKER parameter.
package fwrisc_loader_pkg;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_DONE = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    typedef enum logic [1:0] {
        LOAD = ST_LOAD,
        DONE = ST_DONE,
        FULL = ST_FULL
    } loader_state_e;

    localparam logic [31:0] DEFAULT_END_MARKER     = 32'hFFFF_FFFF;
    localparam int          DEFAULT_ITCM_DEPTH     = 4096;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/fwrisc_byte_packer.sv
// Shifts received bytes into a big-endian word and flags the cycle in which
// the fourth byte arrives; the completed word is presented combinationally.
module fwrisc_byte_packer (
   input  logic        clock,
   input  logic        reset,
   input  logic        en_i,
   input  logic        clear_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic [31:0] word_o,
   output logic        word_valid_o,
   output logic        partial_o
);

   // Only the first three bytes need storage; the fourth is taken straight from the input.
   logic [23:0] shift_q, shift_d;
   logic [1:0]  idx_q, idx_d;
   logic        take;

   assign take         = en_i && rx_valid_i;
   assign word_o       = {shift_q, rx_data_i};
   assign word_valid_o = take && (idx_q == 2'd3);
   assign partial_o    = (idx_q != 2'd0);

   always_comb begin
      shift_d = shift_q;
      idx_d   = idx_q;
      if (clear_i) begin
         shift_d = '0;
         idx_d   = '0;
      end else if (take) begin
         shift_d = {shift_q[15:0], rx_data_i};
         idx_d   = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         shift_q <= '0;
         idx_q   <= '0;
      end else begin
         shift_q <= shift_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: rtl/fwrisc_prog_loader.sv
// Program loader: packs UART bytes into words, writes them to consecutive ITCM
// addresses and releases the core once the end marker, a full ITCM or a timeout ends loading.
module fwrisc_prog_loader
   import fwrisc_loader_pkg::*;
#(
   parameter int          ITCM_DEPTH     = DEFAULT_ITCM_DEPTH,
   parameter int          ADDR_W         = $clog2(ITCM_DEPTH),
   parameter logic [31:0] END_MARKER     = DEFAULT_END_MARKER,
   parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic              rx_en_o,
   output logic              itcm_full_o,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [31:0]       wr_data_o,
   output logic [ADDR_W:0]   word_cnt_o,
   output logic [31:0]       checksum_o,
   output logic              done_o,
   output logic              overflow_o,
   output logic              timeout_err_o,
   output logic              core_hold_o
);

   localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ITCM_DEPTH - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

   loader_state_e     state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [31:0]       csum_q, csum_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              tmo_err_q, tmo_err_d;

   logic              in_load;
   logic              timeout_hit;
   logic [31:0]       word;
   logic              word_valid;
   logic              partial;

   assign in_load     = (state_q == LOAD);
   assign timeout_hit = in_load && partial && !rx_valid_i && (tmo_q == TMO_LAST);

   fwrisc_byte_packer u_packer (
      .clock        (clock),
      .reset        (reset),
      .en_i         (in_load),
      .clear_i      (timeout_hit),
      .rx_data_i    (rx_data_i),
      .rx_valid_i   (rx_valid_i),
      .word_o       (word),
      .word_valid_o (word_valid),
      .partial_o    (partial)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      csum_d    = csum_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      tmo_d     = tmo_q;
      tmo_err_d = tmo_err_q;

      if (in_load) begin
         // The write to the last ITCM word ends loading one cycle after the strobe.
         if (wr_en_q && (wr_addr_q == LAST_ADDR))
            state_d = FULL;

         if (word_valid) begin
            if (word == END_MARKER) begin
               state_d = DONE;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = word;
               addr_d    = (addr_q == LAST_ADDR) ? addr_q : addr_q + 1'b1;
               cnt_d     = cnt_q + 1'b1;
               csum_d    = csum_q + word;
            end
         end

         if (rx_valid_i) begin
            tmo_d = '0;
         end else if (partial) begin
            if (timeout_hit) begin
               state_d   = DONE;
               tmo_err_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end else begin
            tmo_d = '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= LOAD;
         addr_q    <= '0;
         cnt_q     <= '0;
         csum_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         tmo_q     <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         csum_q    <= csum_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         tmo_q     <= tmo_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign rx_en_o       = in_load;
   assign core_hold_o   = in_load;
   assign done_o        = !in_load;
   assign itcm_full_o   = (state_q == FULL);
   assign overflow_o    = (state_q == FULL);
   assign timeout_err_o = tmo_err_q;
   assign wr_en_o       = wr_en_q;
   assign wr_addr_o     = wr_addr_q;
   assign wr_data_o     = wr_data_q;
   assign word_cnt_o    = cnt_q;
   assign checksum_o    = csum_q;

endmodule
